// File: rtl/xentry_pkg.sv
// Shared types for the xentry memory hierarchy: machine word width and the
// memory operation encoding used by the cache-to-L2 request ports.
package xentry_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;

endpackage

// File: rtl/l2_arbiter.sv
// Two-requester L2 port arbiter: icache and dcache share one L2 request port.
// Bursts are never split, ties alternate, and stray completions are flagged.
module l2_arbiter
  import xentry_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_req_valid,
  input  memory_operation_e      ic_req_type,
  input  logic [XLEN-1:0]        ic_req_address,
  output logic                   ic_req_fulfilled,

  input  logic                   dc_req_valid,
  input  memory_operation_e      dc_req_type,
  input  logic [XLEN-1:0]        dc_req_address,
  input  logic [XLEN-1:0]        dc_req_wdata,
  output logic                   dc_req_fulfilled,

  output logic                   l2_req_valid,
  output memory_operation_e      l2_req_type,
  output logic [XLEN-1:0]        l2_req_address,
  output logic [XLEN-1:0]        l2_req_wdata,
  input  logic                   l2_req_fulfilled,

  output logic [1:0]             grant_owner,
  output logic [7:0]             beat_count,
  output logic                   protocol_error
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_IC = 2'd1,
    ST_GRANT_DC = 2'd2
  } state_e;

  state_e state, next_state;
  logic   last_dc;      // dcache held the most recent grant
  logic   owner_valid;

  // NOTE: every signal written here gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state       = state;
    owner_valid      = 1'b0;
    grant_owner      = 2'd0;
    l2_req_type      = LOAD;
    l2_req_address   = '0;
    l2_req_wdata     = '0;
    ic_req_fulfilled = 1'b0;
    dc_req_fulfilled = 1'b0;

    case (state)
      ST_IDLE: begin
        if (ic_req_valid && dc_req_valid)
          next_state = last_dc ? ST_GRANT_IC : ST_GRANT_DC;
        else if (dc_req_valid)
          next_state = ST_GRANT_DC;
        else if (ic_req_valid)
          next_state = ST_GRANT_IC;
      end

      ST_GRANT_IC: begin
        owner_valid      = ic_req_valid;
        grant_owner      = 2'd1;
        l2_req_type      = ic_req_type;
        l2_req_address   = ic_req_address;
        ic_req_fulfilled = ic_req_valid && l2_req_fulfilled;
        if (!ic_req_valid)
          next_state = dc_req_valid ? ST_GRANT_DC : ST_IDLE;
      end

      ST_GRANT_DC: begin
        owner_valid      = dc_req_valid;
        grant_owner      = 2'd2;
        l2_req_type      = dc_req_type;
        l2_req_address   = dc_req_address;
        l2_req_wdata     = dc_req_wdata;
        dc_req_fulfilled = dc_req_valid && l2_req_fulfilled;
        if (!dc_req_valid)
          next_state = ic_req_valid ? ST_GRANT_IC : ST_IDLE;
      end

      default: begin
        // Unreachable encoding: poison everything so it cannot go unnoticed.
        next_state       = state_e'(2'bxx);
        owner_valid      = 1'bx;
        grant_owner      = 2'bxx;
        l2_req_type      = memory_operation_e'(2'bxx);
        l2_req_address   = 'x;
        l2_req_wdata     = 'x;
        ic_req_fulfilled = 1'bx;
        dc_req_fulfilled = 1'bx;
      end
    endcase

    l2_req_valid = owner_valid;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_IDLE;
      last_dc        <= 1'b0;
      beat_count     <= '0;
      protocol_error <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state && next_state != ST_IDLE) begin
        beat_count <= '0;
        last_dc    <= (next_state == ST_GRANT_DC);
      end else if (l2_req_fulfilled && owner_valid && beat_count != 8'hFF) begin
        beat_count <= beat_count + 8'd1;
      end

      // Completion with nobody to deliver it to is dropped and remembered.
      if (l2_req_fulfilled && !owner_valid)
        protocol_error <= 1'b1;
    end
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-low; 0 = reset.
REQ-003 SHALL: ic_req_valid  input  1  icache requests L2; held high for the whole burst.
REQ-004 SHALL: ic_req_type  input  memory_operation_e  icache operation.
REQ-005 SHALL: ic_req_address  input  XLEN  icache word address.
REQ-006 SHALL: ic_req_fulfilled  output  1  icache beat done.
REQ-007 SHALL: dc_req_valid, dc_req_type, dc_req_address, dc_req_wdata  input  1/memory_operation_e/XLEN/XLEN  dcache request, same semantics as icache.
REQ-008 SHALL: dc_req_fulfilled  output  1  dcache beat done.
REQ-009 SHALL: l2_req_valid, l2_req_type, l2_req_address, l2_req_wdata  output  1/memory_operation_e/XLEN/XLEN  request to L2.
REQ-010 SHALL: l2_req_fulfilled  input  1  L2 completes current beat.
REQ-011 SHALL: grant_owner  output  2  0=none, 1=icache, 2=dcache; debug/observability.
REQ-012 SHALL: beat_count  output  8  fulfilled beats in current grant; saturates at 255.
REQ-013 SHALL: protocol_error  output  1  sticky; set on fulfilled with no owner.

Function
REQ-014 SHALL: FSM states ST_IDLE, ST_GRANT_IC, ST_GRANT_DC.
REQ-015 SHALL: ST_IDLE -> ST_GRANT_IC or ST_GRANT_DC on the next edge when one or more requesters are valid; one-cycle arbitration latency.
REQ-016 SHALL: on contention, grant the requester that did not own the last grant; after reset, dcache wins the first tie.
REQ-017 SHALL: grant locked while owner valid high; no preemption; the L2 burst is never split.
REQ-018 SHALL: in ST_GRANT_X with owner valid low, go to the other requester's grant state if it is valid, else to ST_IDLE; zero-bubble handoff.
REQ-019 SHALL: l2_req_valid = owner valid, combinational in a grant state; 0 in ST_IDLE.
REQ-020 SHALL: l2_req_type, l2_req_address, l2_req_wdata mux from the owner; icache wdata is 0.
REQ-021 SHALL: ST_IDLE outputs are type LOAD, address 0, wdata 0.
REQ-022 SHALL: l2_req_fulfilled routes combinationally to the owner's fulfilled only; the non-owner sees 0.
REQ-023 SHALL: beat_count clears on every grant entry, including direct handoff.
REQ-024 SHALL: beat_count increments on each l2_req_fulfilled while the owner is valid.
REQ-025 SHALL: l2_req_fulfilled in ST_IDLE, or while the owner is invalid, is dropped and sets protocol_error.
REQ-026 SHALL: the non-owner's valid may toggle freely with no effect until it is granted.
REQ-027 SHALL: illegal state encodings drive all outputs X and next_state X.

Reset
REQ-028 SHALL: on reset=0 at an edge: state ST_IDLE; last-owner pointer = icache (so dcache wins the first tie); beat_count 0; protocol_error 0.
REQ-029 SHALL: reset mid-burst abandons the grant immediately; outputs are the idle values in the following cycle.
REQ-030 SHALL: protocol_error clears only on reset.

Structure
REQ-031 SHALL: memory_operation_e (LOAD, STORE, MO_UNKNOWN) and XLEN live in xentry_pkg; the arbiter imports them.
REQ-032 SHALL: arbiter state enum is local to the module.
REQ-033 SHALL: single flat module; no sub-module.

Verification
REQ-034 SHALL: single requester: dc valid at cycle 0, STORE to 0x100, wdata 0xDEADBEEF.
- Cycle 1: grant_owner=2; l2 outputs mirror dcache.
- 4 fulfilled pulses give beat_count=4; dc_req_fulfilled pulses 4 times; ic_req_fulfilled stays 0.
REQ-035 SHALL: tie after reset: both valid at cycle 0.
- dcache granted.
- When dc drops valid, icache is granted the same edge, with no l2_req_valid bubble beyond the dc drop cycle.
REQ-036 SHALL: lock: icache owns with 2 of 8 beats done; dc asserts valid.
- Grant stays icache until ic valid drops.
- beat_count reaches 8, then resets to 0 on dcache grant.
REQ-037 SHALL: stray fulfilled: l2_req_fulfilled=1 in ST_IDLE.
- Both fulfilled outputs stay 0.
- protocol_error=1 next cycle and remains 1 until reset.
REQ-038 SHALL: reset mid-burst: reset=0 during a dcache grant.
- Next cycle: grant_owner=0, l2_req_valid=0, beat_count=0.
- After release, a tie grants dcache.
